// File: rtl/mem_stage_ls.sv
// MEM pipeline stage: sized, lane-masked loads/stores against a word memory with
// multi-cycle access latency, misalignment detection, branch resolution and MEM/WB registers.
module mem_stage_ls #(
   parameter int NB_ADDR     = 32,
   parameter int NB_DATA     = 32,
   parameter int NB_PC       = 32,
   parameter int NB_REG      = 5,
   parameter int MEM_DEPTH   = 256,
   parameter int MEM_LATENCY = 2
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_MEM_valid,
   input  logic               i_MEM_reg_write,
   input  logic               i_MEM_mem_to_reg,
   input  logic               i_MEM_mem_read,
   input  logic               i_MEM_mem_write,
   input  logic [1:0]         i_MEM_size,
   input  logic               i_MEM_unsigned,
   input  logic               i_MEM_branch,
   input  logic               i_MEM_zero,
   input  logic [NB_PC-1:0]   i_MEM_branch_addr,
   input  logic [NB_ADDR-1:0] i_MEM_alu_result,
   input  logic [NB_DATA-1:0] i_MEM_write_data,
   input  logic [NB_REG-1:0]  i_MEM_selected_reg,
   output logic               o_MEM_stall,
   output logic               o_branch_zero,
   output logic [NB_PC-1:0]   o_MEM_branch_address,
   output logic               o_WB_valid,
   output logic               o_WB_reg_write,
   output logic               o_WB_mem_to_reg,
   output logic               o_WB_misaligned,
   output logic [NB_DATA-1:0] o_WB_mem_data,
   output logic [NB_ADDR-1:0] o_WB_alu_result,
   output logic [NB_REG-1:0]  o_WB_selected_reg
);

   localparam int NB_IDX = $clog2(MEM_DEPTH);
   localparam int NB_CNT = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;
   localparam logic [NB_CNT-1:0] CNT_LOAD = NB_CNT'((MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t                state_r, state_nxt_s;
   logic [NB_CNT-1:0]     cnt_r, cnt_nxt_s;
   logic [1:0]            addr_lo_s;
   logic [NB_IDX-1:0]     idx_s;
   logic                  access_s, misalign_s, memop_s, stall_s, commit_s;
   logic [3:0]            byte_en_s;
   logic [31:0]           store_word_s, rd_word_s, load_ext_s, load_data_s;
   logic [7:0]            rd_byte_s;
   logic [15:0]           rd_half_s;
   logic [31:0]           mem_r [MEM_DEPTH];

   logic                  wb_valid_r, wb_reg_write_r, wb_mem_to_reg_r, wb_misaligned_r;
   logic [NB_DATA-1:0]    wb_mem_data_r;
   logic [NB_ADDR-1:0]    wb_alu_result_r;
   logic [NB_REG-1:0]     wb_selected_reg_r;

   assign addr_lo_s = i_MEM_alu_result[1:0];
   assign idx_s     = i_MEM_alu_result[NB_IDX+1:2];
   assign access_s  = i_MEM_valid & (i_MEM_mem_read | i_MEM_mem_write);
   assign rd_word_s = mem_r[idx_s];

   // Alignment check and lane enables / replicated store data by access size
   always_comb begin
      misalign_s   = 1'b1;
      byte_en_s    = 4'b0000;
      store_word_s = 32'h0000_0000;
      case (i_MEM_size)
         2'b00: begin
            misalign_s   = 1'b0;
            byte_en_s    = 4'b0001 << addr_lo_s;
            store_word_s = {4{i_MEM_write_data[7:0]}};
         end
         2'b01: begin
            misalign_s   = addr_lo_s[0];
            byte_en_s    = addr_lo_s[1] ? 4'b1100 : 4'b0011;
            store_word_s = {2{i_MEM_write_data[15:0]}};
         end
         2'b10: begin
            misalign_s   = (addr_lo_s != 2'b00);
            byte_en_s    = 4'b1111;
            store_word_s = i_MEM_write_data[31:0];
         end
         default: begin
            misalign_s   = 1'b1;
            byte_en_s    = 4'b0000;
            store_word_s = 32'h0000_0000;
         end
      endcase
   end

   assign memop_s = access_s & ~misalign_s;

   // Latency FSM: a memop stalls until its final cycle, in which it commits
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      stall_s     = 1'b0;
      commit_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (memop_s) begin
               if (MEM_LATENCY > 1) begin
                  stall_s     = 1'b1;
                  cnt_nxt_s   = CNT_LOAD;
                  state_nxt_s = ST_WAIT;
               end else begin
                  commit_s    = 1'b1;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_r != {NB_CNT{1'b0}}) begin
               stall_s   = 1'b1;
               cnt_nxt_s = cnt_r - NB_CNT'(1);
            end else begin
               commit_s    = memop_s;
               state_nxt_s = ST_IDLE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = {NB_CNT{1'b0}};
         end
      endcase
   end

   // Lane selection and sign/zero extension of the load result
   always_comb begin
      rd_half_s = addr_lo_s[1] ? rd_word_s[31:16] : rd_word_s[15:0];
      case (addr_lo_s)
         2'b00:   rd_byte_s = rd_word_s[7:0];
         2'b01:   rd_byte_s = rd_word_s[15:8];
         2'b10:   rd_byte_s = rd_word_s[23:16];
         2'b11:   rd_byte_s = rd_word_s[31:24];
         default: rd_byte_s = 8'h00;
      endcase
      case (i_MEM_size)
         2'b00:   load_ext_s = {{24{rd_byte_s[7] & ~i_MEM_unsigned}}, rd_byte_s};
         2'b01:   load_ext_s = {{16{rd_half_s[15] & ~i_MEM_unsigned}}, rd_half_s};
         default: load_ext_s = rd_word_s;
      endcase
      if (commit_s && i_MEM_mem_read && !i_MEM_mem_write) begin
         load_data_s = load_ext_s;
      end else begin
         load_data_s = 32'h0000_0000;
      end
   end

   // Word memory; contents survive reset, writes only on a committing store
   always_ff @(posedge i_clock) begin
      if (!i_reset && commit_s && i_MEM_mem_write) begin
         for (int l = 0; l < 4; l++) begin
            if (byte_en_s[l]) begin
               mem_r[idx_s][l*8 +: 8] <= store_word_s[l*8 +: 8];
            end
         end
      end
   end

   // FSM state and MEM/WB boundary registers
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_r           <= ST_IDLE;
         cnt_r             <= {NB_CNT{1'b0}};
         wb_valid_r        <= 1'b0;
         wb_reg_write_r    <= 1'b0;
         wb_mem_to_reg_r   <= 1'b0;
         wb_misaligned_r   <= 1'b0;
         wb_mem_data_r     <= {NB_DATA{1'b0}};
         wb_alu_result_r   <= {NB_ADDR{1'b0}};
         wb_selected_reg_r <= {NB_REG{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         if (stall_s) begin
            wb_valid_r     <= 1'b0;
            wb_reg_write_r <= 1'b0;
         end else begin
            wb_valid_r        <= i_MEM_valid;
            wb_reg_write_r    <= i_MEM_valid & i_MEM_reg_write & ~(access_s & misalign_s);
            wb_mem_to_reg_r   <= i_MEM_mem_to_reg;
            wb_misaligned_r   <= access_s & misalign_s;
            wb_mem_data_r     <= NB_DATA'(load_data_s);
            wb_alu_result_r   <= i_MEM_alu_result;
            wb_selected_reg_r <= i_MEM_selected_reg;
         end
      end
   end

   assign o_MEM_stall          = stall_s & ~i_reset;
   assign o_branch_zero        = i_MEM_valid & i_MEM_branch & i_MEM_zero;
   assign o_MEM_branch_address = i_MEM_branch_addr;
   assign o_WB_valid           = wb_valid_r;
   assign o_WB_reg_write       = wb_reg_write_r;
   assign o_WB_mem_to_reg      = wb_mem_to_reg_r;
   assign o_WB_misaligned      = wb_misaligned_r;
   assign o_WB_mem_data        = wb_mem_data_r;
   assign o_WB_alu_result      = wb_alu_result_r;
   assign o_WB_selected_reg    = wb_selected_reg_r;

endmodule

// File: tb/tb_mem_stage_ls.sv
// Bench for mem_stage_ls: one instance at latency 1 and one at latency 3, each checked every
// cycle against a transaction-level model (per-instruction cycle budget plus a byte-lane memory).
module tb_mem_stage_ls;

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic        mem_to_reg;
      logic        mem_read;
      logic        mem_write;
      logic [1:0]  size;
      logic        uns;
      logic        branch;
      logic        zero;
      logic [31:0] baddr;
      logic [31:0] alu;
      logic [31:0] wdata;
      logic [4:0]  sel;
   } instr_t;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   instr_t din [2];

   logic        stall [2], bz [2], wv [2], wrw [2], wm2r [2], wmis [2];
   logic [31:0] bad [2], wdat [2], walu [2];
   logic [4:0]  wsel [2];

   int checks = 0;
   int failures = 0;

   // model state
   int          age [2] = '{0, 0};
   logic        e_valid [2], e_rw [2], e_m2r [2], e_mis [2];
   logic [31:0] e_data [2], e_alu [2];
   logic [4:0]  e_sel [2];
   logic [31:0] mm [2][256];

   always #5 clk = ~clk;

   mem_stage_ls #(.MEM_LATENCY(1)) u_lat1 (
      .i_clock(clk), .i_reset(rst),
      .i_MEM_valid(din[0].valid), .i_MEM_reg_write(din[0].reg_write),
      .i_MEM_mem_to_reg(din[0].mem_to_reg), .i_MEM_mem_read(din[0].mem_read),
      .i_MEM_mem_write(din[0].mem_write), .i_MEM_size(din[0].size),
      .i_MEM_unsigned(din[0].uns), .i_MEM_branch(din[0].branch), .i_MEM_zero(din[0].zero),
      .i_MEM_branch_addr(din[0].baddr), .i_MEM_alu_result(din[0].alu),
      .i_MEM_write_data(din[0].wdata), .i_MEM_selected_reg(din[0].sel),
      .o_MEM_stall(stall[0]), .o_branch_zero(bz[0]), .o_MEM_branch_address(bad[0]),
      .o_WB_valid(wv[0]), .o_WB_reg_write(wrw[0]), .o_WB_mem_to_reg(wm2r[0]),
      .o_WB_misaligned(wmis[0]), .o_WB_mem_data(wdat[0]), .o_WB_alu_result(walu[0]),
      .o_WB_selected_reg(wsel[0])
   );

   mem_stage_ls #(.MEM_LATENCY(3)) u_lat3 (
      .i_clock(clk), .i_reset(rst),
      .i_MEM_valid(din[1].valid), .i_MEM_reg_write(din[1].reg_write),
      .i_MEM_mem_to_reg(din[1].mem_to_reg), .i_MEM_mem_read(din[1].mem_read),
      .i_MEM_mem_write(din[1].mem_write), .i_MEM_size(din[1].size),
      .i_MEM_unsigned(din[1].uns), .i_MEM_branch(din[1].branch), .i_MEM_zero(din[1].zero),
      .i_MEM_branch_addr(din[1].baddr), .i_MEM_alu_result(din[1].alu),
      .i_MEM_write_data(din[1].wdata), .i_MEM_selected_reg(din[1].sel),
      .o_MEM_stall(stall[1]), .o_branch_zero(bz[1]), .o_MEM_branch_address(bad[1]),
      .o_WB_valid(wv[1]), .o_WB_reg_write(wrw[1]), .o_WB_mem_to_reg(wm2r[1]),
      .o_WB_misaligned(wmis[1]), .o_WB_mem_data(wdat[1]), .o_WB_alu_result(walu[1]),
      .o_WB_selected_reg(wsel[1])
   );

   function automatic int lat_of(int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic logic is_aligned(instr_t x);
      case (x.size)
         2'd0:    return 1'b1;
         2'd1:    return ~x.alu[0];
         2'd2:    return (x.alu[1:0] == 2'd0);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic memop(instr_t x);
      return x.valid & (x.mem_read | x.mem_write) & is_aligned(x);
   endfunction

   function automatic logic misflag(instr_t x);
      return x.valid & (x.mem_read | x.mem_write) & ~is_aligned(x);
   endfunction

   function automatic int nbytes(instr_t x);
      return (x.size == 2'd0) ? 1 : (x.size == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] load_val(logic [31:0] w, instr_t x);
      int base, n;
      logic [31:0] mask, r;
      base = int'(x.alu[1:0]);
      n    = nbytes(x);
      r    = w >> (8 * base);
      if (n == 4) return r;
      mask = (32'd1 << (8 * n)) - 32'd1;
      r = r & mask;
      if (!x.uns && r[8*n-1]) r = r | ~mask;
      return r;
   endfunction

   function automatic logic [31:0] store_word(logic [31:0] w, instr_t x);
      int base;
      base = int'(x.alu[1:0]);
      for (int i = 0; i < nbytes(x); i++) w[8*(base+i) +: 8] = x.wdata[8*i +: 8];
      return w;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: a memop occupies lat cycles, everything else one
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            age[d] <= 0;
            e_valid[d] <= 1'b0; e_rw[d] <= 1'b0; e_m2r[d] <= 1'b0; e_mis[d] <= 1'b0;
            e_data[d] <= 32'd0; e_alu[d] <= 32'd0; e_sel[d] <= 5'd0;
         end else if (memop(din[d]) && age[d] < lat_of(d) - 1) begin
            age[d]     <= age[d] + 1;
            e_valid[d] <= 1'b0;
            e_rw[d]    <= 1'b0;
         end else begin
            age[d]     <= 0;
            e_valid[d] <= din[d].valid;
            e_rw[d]    <= din[d].valid & din[d].reg_write & ~misflag(din[d]);
            e_m2r[d]   <= din[d].mem_to_reg;
            e_mis[d]   <= misflag(din[d]);
            e_alu[d]   <= din[d].alu;
            e_sel[d]   <= din[d].sel;
            e_data[d]  <= (memop(din[d]) && din[d].mem_read && !din[d].mem_write)
                          ? load_val(mm[d][din[d].alu[9:2]], din[d]) : 32'd0;
            if (memop(din[d]) && din[d].mem_write)
               mm[d][din[d].alu[9:2]] <= store_word(mm[d][din[d].alu[9:2]], din[d]);
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("stall[%0d]", d), 32'(stall[d]),
             32'(!rst && memop(din[d]) && age[d] < lat_of(d) - 1));
         chk($sformatf("branch_zero[%0d]", d), 32'(bz[d]),
             32'(din[d].valid & din[d].branch & din[d].zero));
         chk($sformatf("branch_addr[%0d]", d), bad[d], din[d].baddr);
         chk($sformatf("wb_valid[%0d]", d), 32'(wv[d]), 32'(e_valid[d]));
         chk($sformatf("wb_reg_write[%0d]", d), 32'(wrw[d]), 32'(e_rw[d]));
         if (e_valid[d]) begin
            chk($sformatf("wb_mem_data[%0d]", d), wdat[d], e_data[d]);
            chk($sformatf("wb_misaligned[%0d]", d), 32'(wmis[d]), 32'(e_mis[d]));
            chk($sformatf("wb_mem_to_reg[%0d]", d), 32'(wm2r[d]), 32'(e_m2r[d]));
            chk($sformatf("wb_alu[%0d]", d), walu[d], e_alu[d]);
            chk($sformatf("wb_sel[%0d]", d), 32'(wsel[d]), 32'(e_sel[d]));
         end
      end
   end

   function automatic instr_t mk(logic rd, logic wr, logic [1:0] sz, logic uns,
                                 logic [31:0] addr, logic [31:0] wd);
      instr_t x;
      x = '0;
      x.valid = 1'b1; x.reg_write = ~wr; x.mem_to_reg = rd;
      x.mem_read = rd; x.mem_write = wr; x.size = sz; x.uns = uns;
      x.alu = addr; x.wdata = wd; x.sel = 5'd9;
      return x;
   endfunction

   // Presents x to DUT d until it completes; returns after the edge that registers it.
   task automatic issue(int d, instr_t x, output int nstall);
      din[d] = x;
      nstall = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (!stall[d]) break;
         nstall++;
      end
      if (nstall >= 10) chk($sformatf("stall_timeout[%0d]", d), 32'(nstall), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic ld_check(int d, instr_t x, logic [31:0] exp, int exp_stall, string name);
      int n;
      issue(d, x, n);
      chk({name, "_data"}, wdat[d], exp);
      chk({name, "_stalls"}, 32'(n), 32'(exp_stall));
      chk({name, "_valid"}, 32'(wv[d]), 32'd1);
   endtask

   initial begin
      int n;
      instr_t x;
      din[0] = '0;
      din[1] = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_wb_valid", 32'(wv[d]), 32'd0);
         chk("rst_wb_data", wdat[d], 32'd0);
         chk("rst_wb_rw", 32'(wrw[d]), 32'd0);
         chk("rst_wb_mis", 32'(wmis[d]), 32'd0);
         chk("rst_stall", 32'(stall[d]), 32'd0);
      end
      rst = 1'b0;

      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 16; i++) issue(d, mk(1'b0, 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom), n);

      // latency 1 directed
      issue(0, mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF), n);
      chk("l1_sw_stalls", 32'(n), 32'd0);
      ld_check(0, mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0), 32'hDEADBEEF, 0, "l1_lw");
      issue(0, mk(1'b0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h00000077), n);
      ld_check(0, mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0), 32'hDEAD77EF, 0, "l1_lw_after_sb");
      ld_check(0, mk(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'd0), 32'hFFFFFFDE, 0, "l1_lb");
      ld_check(0, mk(1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'd0), 32'h000000DE, 0, "l1_lbu");
      ld_check(0, mk(1'b1, 1'b0, 2'd1, 1'b0, 32'h12, 32'd0), 32'hFFFFDEAD, 0, "l1_lh");
      issue(0, mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h12, 32'h12345678), n);
      chk("l1_sw_mis_flag", 32'(wmis[0]), 32'd1);
      ld_check(0, mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0), 32'hDEAD77EF, 0, "l1_mem_unchanged");

      // latency 3 directed
      issue(1, mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF), n);
      chk("l3_sw_stalls", 32'(n), 32'd2);
      ld_check(1, mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0), 32'hDEADBEEF, 2, "l3_lw");
      issue(1, mk(1'b0, 1'b0, 2'd2, 1'b0, 32'h1234, 32'd0), n);
      chk("l3_add_stalls", 32'(n), 32'd0);
      chk("l3_add_alu", walu[1], 32'h1234);
      chk("l3_add_valid", 32'(wv[1]), 32'd1);
      issue(1, mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h02, 32'd0), n);
      chk("l3_lw_mis_stalls", 32'(n), 32'd0);
      chk("l3_lw_mis_flag", 32'(wmis[1]), 32'd1);
      chk("l3_lw_mis_rw", 32'(wrw[1]), 32'd0);
      issue(1, mk(1'b1, 1'b0, 2'd1, 1'b0, 32'h01, 32'd0), n);
      chk("l3_lh_mis_stalls", 32'(n), 32'd0);
      chk("l3_lh_mis_flag", 32'(wmis[1]), 32'd1);
      chk("l3_lh_mis_data", wdat[1], 32'd0);

      // reset during the second stall cycle of a store
      issue(1, mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'hA5A5A5A5), n);
      din[1] = mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h5A5A5A5A);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("abort_stall", 32'(stall[1]), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      din[1] = '0;
      chk("abort_wb_valid", 32'(wv[1]), 32'd0);
      chk("abort_wb_data", wdat[1], 32'd0);
      ld_check(1, mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0), 32'hA5A5A5A5, 2, "abort_old_value");

      // branch resolution
      x = '0; x.valid = 1'b1; x.branch = 1'b1; x.zero = 1'b1; x.baddr = 32'h400;
      din[0] = x;
      #1;
      chk("branch_taken", 32'(bz[0]), 32'd1);
      chk("branch_target", bad[0], 32'h400);
      x.zero = 1'b0;
      din[0] = x;
      #1;
      chk("branch_not_taken", 32'(bz[0]), 32'd0);
      @(posedge clk);
      #1;

      // randomized traffic
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 200; i++) begin
            x.valid      = ($urandom_range(0, 7) != 0);
            x.reg_write  = 1'($urandom);
            x.mem_to_reg = 1'($urandom);
            x.mem_read   = 1'($urandom);
            x.mem_write  = 1'($urandom);
            x.size       = 2'($urandom);
            x.uns        = 1'($urandom);
            x.branch     = 1'($urandom);
            x.zero       = 1'($urandom);
            x.baddr      = $urandom;
            x.alu        = $urandom & 32'h0000_0C3F;
            x.wdata      = $urandom;
            x.sel        = 5'($urandom);
            issue(d, x, n);
         end
         din[d] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
